dcsk_mod: RTL and testbench
===========================

Name: dcsk_mod

Overview:
- DCSK transmitter; the counterpart of the receiver demodulator data path.
- Accepts a parallel data word over a valid/ready handshake and serialises it LSB-first.
- Each data bit becomes one symbol of 2*SF chips: SF chaotic reference chips, then SF data chips.
- Data chips equal the reference chips for bit 1 and their inverse for bit 0, so the receiver's XNOR correlator majority-votes 1 for bit 1.

Parameters:
- NUM_BITS, 32, data bits per frame; legal range 2..32.
- LFSR_SEED, 16'hACE1, chaos generator reset value. A value of 0 is replaced by 16'h0001.

Ports:
- Clk  in  1  clock.
- N_Rst  in  1  reset, asynchronous, active-low.
- In_Data  in  NUM_BITS  frame payload; bit 0 is transmitted first.
- In_Valid  in  1  payload valid.
- In_Ready  out  1  block idle and able to accept a frame.
- Spread_Factor_Sel  in  2  selects SF: 00=2, 01=4, 10=8, 11=16. Sampled only on acceptance.
- Tx_Abort  in  1  synchronous frame abort.
- Out_Mod_Data  out  1  modulated chip; 0 when Out_Chip_Valid is low.
- Out_Chip_Valid  out  1  chip on Out_Mod_Data is valid.
- Out_Phase  out  1  0 = reference half, 1 = data half; 0 when not valid.
- Frame_Done  out  1  one-cycle pulse coincident with the last chip of the frame.

Behaviour:
- Reset values:
  - In_Ready=1; Out_Mod_Data, Out_Chip_Valid, Out_Phase, Frame_Done = 0.
  - FSM to IDLE; all counters 0; delay register 0; LFSR = seed.
- Reset asserted mid-frame drops the frame immediately, with no Frame_Done.
- FSM states: IDLE, REF, DATA.
  - IDLE: In_Ready=1. On In_Valid&&In_Ready: latch In_Data into the shift register, latch SF, clear chip_cnt and bit_cnt, go to REF.
  - REF, per cycle: chip = LFSR[0]; DelReg[chip_cnt] <= chip; LFSR steps; chip_cnt++. After chip_cnt==SF-1: chip_cnt=0, go to DATA.
  - DATA, per cycle: chip = ~(DelReg[chip_cnt] ^ cur_bit), where cur_bit = shift_reg[0]. The LFSR holds. After chip_cnt==SF-1: chip_cnt=0, shift the register right, bit_cnt++.
    - If bit_cnt was NUM_BITS-1: go to IDLE and pulse Frame_Done with that chip.
    - Otherwise go to REF.
- Outputs are registered. The first reference chip appears the cycle after the acceptance edge.
- A frame lasts exactly NUM_BITS*2*SF cycles of Out_Chip_Valid=1, with no gaps.
- In_Ready deasserts in the cycle after acceptance and reasserts the cycle after the last chip. There is a minimum of one idle cycle between frames.
- Changes on In_Data or Spread_Factor_Sel during a frame are ignored.
- Widths:
  - chip_cnt: 4 bits, compared against SF-1.
  - bit_cnt: 5 bits.
  - DelReg: 16 bits; only entries [SF-1:0] are used.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting right.
  - The feedback bit enters bit 15.
  - Its state persists across frames and is not reseeded.
- Tx_Abort:
  - In REF or DATA: go to IDLE next cycle, Out_Chip_Valid=0 next cycle, no Frame_Done. The LFSR keeps its state.
  - In IDLE it is ignored.
  - If it arrives together with In_Valid in IDLE, the acceptance wins.
- If the last chip and Tx_Abort coincide, the frame completes normally and Frame_Done pulses.

Decomposition:
- Package dcsk_pkg holds:
  - state typedef (IDLE/REF/DATA);
  - function sf_decode(sel) returning 5-bit SF;
  - LFSR tap constant and width constant (16);
  - SF_MAX=16.
- One sub-module, dcsk_chaos_lfsr, with inputs Clk, N_Rst, Step and output Chip, parameterised by seed.

Test Plan:
1. SF=2, In_Data=32'hFFFFFFFF:
   - Each symbol is 4 chips, with chips[2:3]==chips[0:1].
   - 128 valid cycles; Frame_Done on cycle 128.
   - In_Ready low for exactly 128 cycles.
2. SF=4, In_Data=32'h00000000: every data chip equals the inverse of the reference chip at the same offset; Out_Phase pattern is 0000_1111 repeated.
3. Loopback into a behavioural demodulator model (XNOR correlator, majority vote, LSB-first). For each SF in {2,4,8,16} with In_Data=32'hA5A53C96, the recovered word equals 32'hA5A53C96.
4. Back-to-back frames:
   - In_Valid held high for two frames: second acceptance occurs one cycle after Frame_Done.
   - Reference chips of frame 2 continue the LFSR sequence from frame 1, not from the seed.
5. Tx_Abort at cycle 37 of an SF=8 frame:
   - Out_Chip_Valid=0 from cycle 38; no Frame_Done; In_Ready=1.
   - The next frame's first reference chip equals the LFSR output following the last aborted REF chip.
6. N_Rst pulsed low mid-DATA phase: all outputs 0 immediately; after release, the first chip of a new frame equals LFSR_SEED[0]=1.

Source files
------------

// File: rtl/dcsk_pkg.sv
// dcsk_pkg: shared types, constants and helpers for the DCSK transmitter
package dcsk_pkg;
  localparam int LFSR_W = 16;
  // Feedback taps at bits 0,2,3,5 of a right-shifting register realise x^16+x^14+x^13+x^11+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
  localparam int SF_MAX = 16;
  typedef enum logic [1:0] {IDLE, REF, DATA} state_t;
  function automatic logic [4:0] sf_decode(input logic [1:0] sel);
    return 5'd2 << sel;
  endfunction
endpackage

// File: rtl/dcsk_chaos_lfsr.sv
// dcsk_chaos_lfsr: 16-bit Fibonacci LFSR supplying chaotic reference chips
module dcsk_chaos_lfsr
  import dcsk_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic Clk,
  input  logic N_Rst,
  input  logic Step,
  output logic Chip
);
  // An all-zero state would lock up, so a zero seed falls back to 1
  localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? 16'h0001 : SEED;
  logic [LFSR_W-1:0] lfsr;
  // Advance one position per consumed reference chip, feedback into the MSB
  always_ff @(posedge Clk or negedge N_Rst)
    if (!N_Rst) lfsr <= INIT;
    else if (Step) lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
  assign Chip = lfsr[0];
endmodule

// File: rtl/dcsk_mod.sv
// dcsk_mod: DCSK transmitter serialising a data word into reference/data chip pairs
module dcsk_mod
  import dcsk_pkg::*;
#(
  parameter int NUM_BITS = 32,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic                Clk,
  input  logic                N_Rst,
  input  logic [NUM_BITS-1:0] In_Data,
  input  logic                In_Valid,
  output logic                In_Ready,
  input  logic [1:0]          Spread_Factor_Sel,
  input  logic                Tx_Abort,
  output logic                Out_Mod_Data,
  output logic                Out_Chip_Valid,
  output logic                Out_Phase,
  output logic                Frame_Done
);
  state_t              state;
  logic [3:0]          chip_cnt;
  logic [4:0]          bit_cnt;
  logic [4:0]          sf;
  logic [NUM_BITS-1:0] shift_reg;
  logic [SF_MAX-1:0]   del_reg;
  logic                lfsr_chip;
  logic                accept;
  logic                emit;
  logic                e_data;
  logic                e_last;
  logic                chip;
  logic                step;
  logic                frame_end;
  logic [4:0]          e_sf;
  logic [3:0]          e_cnt;

  dcsk_chaos_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk  (Clk),
    .N_Rst(N_Rst),
    .Step (step),
    .Chip (lfsr_chip)
  );

  // The state/counters name the chip produced at the next edge; acceptance itself emits reference chip 0
  always_comb begin
    accept    = state == IDLE && In_Ready && In_Valid;
    emit      = accept || (state != IDLE && !Tx_Abort);
    e_sf      = accept ? sf_decode(Spread_Factor_Sel) : sf;
    e_data    = !accept && state == DATA;
    e_cnt     = accept ? 4'd0 : chip_cnt;
    e_last    = e_cnt == 4'(e_sf - 5'd1);
    chip      = e_data ? ~(del_reg[e_cnt] ^ shift_reg[0]) : lfsr_chip;
    step      = emit && !e_data;
    frame_end = e_data && e_last && bit_cnt == 5'(NUM_BITS - 1);
  end

  // Frame sequencer with registered chip outputs; In_Ready stays low through the last chip
  always_ff @(posedge Clk or negedge N_Rst)
    if (!N_Rst) begin
      state          <= IDLE;
      chip_cnt       <= '0;
      bit_cnt        <= '0;
      sf             <= '0;
      shift_reg      <= '0;
      del_reg        <= '0;
      In_Ready       <= 1'b1;
      Out_Mod_Data   <= 1'b0;
      Out_Chip_Valid <= 1'b0;
      Out_Phase      <= 1'b0;
      Frame_Done     <= 1'b0;
    end else begin
      Out_Mod_Data   <= emit && chip;
      Out_Chip_Valid <= emit;
      Out_Phase      <= emit && e_data;
      Frame_Done     <= emit && frame_end;
      In_Ready       <= !emit;
      if (accept) begin
        shift_reg <= In_Data;
        sf        <= e_sf;
        bit_cnt   <= '0;
      end
      if (step) del_reg[e_cnt] <= lfsr_chip;
      if (!emit) begin
        state    <= IDLE;
        chip_cnt <= '0;
      end else if (e_data) begin
        chip_cnt <= e_last ? 4'd0 : chip_cnt + 4'd1;
        if (e_last) begin
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + 5'd1;
          state     <= frame_end ? IDLE : REF;
        end
      end else begin
        chip_cnt <= e_last ? 4'd0 : e_cnt + 4'd1;
        state    <= e_last ? DATA : REF;
      end
    end
endmodule

// File: tb/tb_dcsk_mod.sv
// tb_dcsk_mod: randomized self-checking bench with a frame-level DCSK reference model
module tb_dcsk_mod;
  localparam int NB = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        Clk = 0;
  logic        N_Rst = 0;
  logic [31:0] In_Data = 0;
  logic        In_Valid = 0;
  logic        In_Ready;
  logic [1:0]  Spread_Factor_Sel = 0;
  logic        Tx_Abort = 0;
  logic        Out_Mod_Data;
  logic        Out_Chip_Valid;
  logic        Out_Phase;
  logic        Frame_Done;

  dcsk_mod #(.NUM_BITS(NB), .LFSR_SEED(SEED)) dut (
    .Clk(Clk), .N_Rst(N_Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Spread_Factor_Sel(Spread_Factor_Sel), .Tx_Abort(Tx_Abort), .Out_Mod_Data(Out_Mod_Data),
    .Out_Chip_Valid(Out_Chip_Valid), .Out_Phase(Out_Phase), .Frame_Done(Frame_Done)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  typedef struct packed {logic v; logic chip; logic ph; logic done; logic [15:0] lf;} ent_t;
  ent_t        q[$];
  ent_t        cur = '0;
  bit          m_rdy = 1;
  logic [15:0] m_lfsr = SEED;

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Expand a whole frame into its expected chip stream, recording the LFSR state after each chip
  function automatic void gen_frame(input logic [31:0] d, input int sf);
    logic r[16];
    ent_t e;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < sf; i++) begin
        r[i] = m_lfsr[0];
        m_lfsr = lstep(m_lfsr);
        e = '{v: 1'b1, chip: r[i], ph: 1'b0, done: 1'b0, lf: m_lfsr};
        q.push_back(e);
      end
      for (int i = 0; i < sf; i++) begin
        e = '{v: 1'b1, chip: d[b] ? r[i] : !r[i], ph: 1'b1, done: (b == NB - 1 && i == sf - 1), lf: m_lfsr};
        q.push_back(e);
      end
    end
  endfunction

  // Reference model: what each cycle must show, derived from accepted frames and aborts
  always @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      q.delete();
      cur = '0;
      m_rdy = 1;
      m_lfsr = SEED;
    end else begin
      if (cur.v && !cur.done && Tx_Abort) begin
        q.delete();
        m_lfsr = cur.lf;
      end
      if (q.size() == 0 && m_rdy && In_Valid) gen_frame(In_Data, 2 << Spread_Factor_Sel);
      cur = (q.size() != 0) ? q.pop_front() : '0;
      m_rdy = !cur.v;
    end
  end

  logic [1:0] cap[$];
  bit  done_seen = 0;
  bit  pv = 0;
  int  done_idx = 0;
  int  rdy_low = 0;
  int  cyc = 0;
  int  rise_cyc = 0;
  int  done_cyc = 0;

  // Compare every cycle against the model and capture the chip stream for frame-level checks
  always @(negedge Clk) begin
    chk("valid", Out_Chip_Valid, cur.v);
    chk("chip", Out_Mod_Data, cur.chip);
    chk("phase", Out_Phase, cur.ph);
    chk("done", Frame_Done, cur.done);
    chk("ready", In_Ready, m_rdy);
    cyc++;
    if (!In_Ready) rdy_low++;
    if (Out_Chip_Valid) begin
      cap.push_back({Out_Phase, Out_Mod_Data});
      if (!pv) rise_cyc = cyc;
    end
    if (Frame_Done) begin
      done_seen = 1;
      done_idx = cap.size();
      done_cyc = cyc;
    end
    pv = Out_Chip_Valid;
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] s, input bit hold, input bit ab);
    int n;
    n = 0;
    cap.delete();
    done_seen = 0;
    rdy_low = 0;
    In_Data = d;
    Spread_Factor_Sel = s;
    In_Valid = 1;
    Tx_Abort = ab;
    while (!In_Ready && n < 3000) begin
      tick();
      n++;
    end
    chk("accept_timeout", n < 3000, 1);
    tick();
    In_Valid = hold;
    Tx_Abort = 0;
    In_Data = $urandom;
    Spread_Factor_Sel = 2'($urandom);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!done_seen && n < 3000) begin
      tick();
      n++;
    end
    chk("done_timeout", n < 3000, 1);
    tick();
  endtask

  task automatic abort_at(input int k);
    int nv;
    int n;
    nv = 0;
    n = 0;
    while (n < 3000) begin
      if (Out_Chip_Valid) nv++;
      if (nv == k) break;
      tick();
      n++;
    end
    chk("abort_timeout", n < 3000, 1);
    Tx_Abort = 1;
    tick();
    Tx_Abort = 0;
  endtask

  function automatic logic [31:0] demod(input int sf);
    logic [31:0] r;
    int v;
    r = 0;
    for (int b = 0; b < NB; b++) begin
      v = 0;
      for (int i = 0; i < sf; i++)
        if (cap[b * 2 * sf + i][0] == cap[b * 2 * sf + sf + i][0]) v++;
      r[b] = 2 * v > sf;
    end
    return r;
  endfunction

  initial begin
    int mism;
    int n;
    logic [7:0] f;
    tick();
    tick();
    chk("rst_ready", In_Ready, 1);
    chk("rst_valid", Out_Chip_Valid, 0);
    N_Rst = 1;
    tick();

    // SF=2, all ones: data half repeats the reference half
    send(32'hFFFFFFFF, 2'd0, 0, 0);
    wait_end();
    chk("t1_len", cap.size(), 128);
    chk("t1_done_idx", done_idx, 128);
    chk("t1_ready_low", rdy_low, 128);
    f = 0;
    for (int i = 0; i < 8; i++) f[i] = cap[i][0];
    chk("t1_first8", f, 8'b0000_0101);
    mism = 0;
    for (int k = 0; k < cap.size(); k++)
      if (k % 4 >= 2 && cap[k][0] != cap[k - 2][0]) mism++;
    chk("t1_repeat", mism, 0);

    // SF=4, all zeros: data half is the inverted reference, phase 0000_1111
    send(32'h0, 2'd1, 0, 0);
    wait_end();
    mism = 0;
    for (int k = 0; k < cap.size(); k++) begin
      if (cap[k][1] != (k % 8 >= 4)) mism++;
      if (k % 8 >= 4 && cap[k][0] == cap[k - 4][0]) mism++;
    end
    chk("t2_len", cap.size(), 256);
    chk("t2_phase_inv", mism, 0);

    // Loopback through a correlator demodulator for every spreading factor
    for (int s = 0; s < 4; s++) begin
      send(32'hA5A53C96, 2'(s), 0, 0);
      wait_end();
      chk("t3_loopback", demod(2 << s), 32'hA5A53C96);
    end

    // Back-to-back frames with In_Valid held high
    send(32'h12345678, 2'd0, 1, 0);
    wait_end();
    done_seen = 0;
    repeat (4) tick();
    chk("t4_gap", rise_cyc - done_cyc, 2);
    In_Valid = 0;
    wait_end();

    // Abort on chip 37 of an SF=8 frame
    send(32'hDEADBEEF, 2'd2, 0, 0);
    abort_at(37);
    chk("t5_valid", Out_Chip_Valid, 0);
    chk("t5_ready", In_Ready, 1);
    chk("t5_no_done", done_seen, 0);
    send(32'hCAFEF00D, 2'd1, 0, 0);
    wait_end();

    // Asynchronous reset during a data half
    send(32'h0F0F0F0F, 2'd1, 0, 0);
    n = 0;
    while (!Out_Phase && n < 100) begin
      tick();
      n++;
    end
    chk("t6_reach_data", Out_Phase, 1);
    #1 N_Rst = 0;
    #1;
    chk("t6_rst_valid", Out_Chip_Valid, 0);
    chk("t6_rst_data", Out_Mod_Data, 0);
    chk("t6_rst_phase", Out_Phase, 0);
    chk("t6_rst_done", Frame_Done, 0);
    chk("t6_rst_ready", In_Ready, 1);
    tick();
    tick();
    N_Rst = 1;
    tick();
    send($urandom, 2'd0, 0, 0);
    chk("t6_first_valid", Out_Chip_Valid, 1);
    chk("t6_first_chip", Out_Mod_Data, 1);
    wait_end();

    // Randomized frames, spreading factors, gaps and aborts
    for (int it = 0; it < 10; it++) begin
      int sel;
      sel = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) tick();
      send($urandom, 2'(sel), 0, $urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        abort_at($urandom_range(1, NB * 4 * (1 << sel)));
        tick();
        tick();
      end else begin
        wait_end();
      end
    end
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
